// File: rtl/ascii_field_streamer.sv
// Serializes a packed, right-justified ASCII field as a byte stream, leftmost character first.
// NUL bytes are dropped; an optional CR LF trailer closes each field.
module ascii_field_streamer #(
    parameter int INPUT_WIDTH = 19,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [INPUT_WIDTH*8-1:0] field_i,
    input  logic                     start_i,
    output logic                     idle_o,
    output logic [7:0]               tdata_o,
    output logic                     tvalid_o,
    input  logic                     tready_i,
    output logic                     tlast_o
);

    localparam int IDX_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_SEND,
        S_CR,
        S_LF
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic               latch_en;

    logic [7:0]             char_q [INPUT_WIDTH];
    logic [INPUT_WIDTH-1:0] nz_q;
    logic [INPUT_WIDTH-1:0] nz_field;
    logic [INPUT_WIDTH-1:0] below_mask;
    logic [7:0]             cur_char;
    logic                   idx_zero;
    logic                   below_none;

    // Per-character latch, nonzero flags and the "positions below idx" mask.
    generate
        for (genvar gi = 0; gi < INPUT_WIDTH; gi++) begin : g_char
            assign nz_field[gi]   = |field_i[gi*8 +: 8];
            assign below_mask[gi] = (IDX_W'(gi) < idx_q);

            always_ff @(posedge clk_i) begin
                if (latch_en) begin
                    char_q[gi] <= field_i[gi*8 +: 8];
                end
            end
        end
    endgenerate

    assign cur_char   = char_q[idx_q];
    assign idx_zero   = (idx_q == '0);
    // Lookahead: nothing printable remains once the current character is gone.
    assign below_none = ~|(nz_q & below_mask);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            tdata_q  <= 8'h00;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            nz_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            if (latch_en) begin
                nz_q <= nz_field;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        latch_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    latch_en = 1'b1;
                    idx_d    = IDX_W'(INPUT_WIDTH - 1);
                    state_d  = S_SCAN;
                end
            end

            S_SCAN: begin
                if (cur_char != 8'h00) begin
                    tdata_d  = cur_char;
                    tvalid_d = 1'b1;
                    tlast_d  = !APPEND_CRLF && below_none;
                    state_d  = S_SEND;
                end else if (!idx_zero) begin
                    idx_d = idx_q - 1'b1;
                end else if (APPEND_CRLF) begin
                    tdata_d  = 8'h0D;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    state_d  = S_CR;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SEND: begin
                if (tready_i) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (idx_zero || below_none) begin
                        if (APPEND_CRLF) begin
                            // CR is loaded straight away so the beat stream stays gap-free.
                            tdata_d  = 8'h0D;
                            tvalid_d = 1'b1;
                            state_d  = S_CR;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = S_SCAN;
                    end
                end
            end

            S_CR: begin
                if (tready_i) begin
                    tdata_d  = 8'h0A;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b1;
                    state_d  = S_LF;
                end
            end

            S_LF: begin
                if (tready_i) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d  = S_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
    end

    assign idle_o   = (state_q == S_IDLE) && !start_i;
    assign tdata_o  = tdata_q;
    assign tvalid_o = tvalid_q;
    assign tlast_o  = tlast_q;

endmodule

// File: tb/tb_ascii_field_streamer.sv
// Drives two streamer instances (with and without CR LF) and checks their byte streams
// against a queue-based reference built directly from the field contents.
module tb_ascii_field_streamer;

    localparam int W = 19;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           tready;
    logic           sel;
    logic [W*8-1:0] field;

    logic       start1, idle1, tvalid1, tlast1;
    logic [7:0] tdata1;
    logic       start0, idle0, tvalid0, tlast0;
    logic [7:0] tdata0;
    logic       o_idle, o_tvalid, o_tlast;
    logic [7:0] o_tdata;

    always #5 clk = ~clk;

    assign start1   = start & sel;
    assign start0   = start & ~sel;
    assign o_idle   = sel ? idle1 : idle0;
    assign o_tvalid = sel ? tvalid1 : tvalid0;
    assign o_tlast  = sel ? tlast1 : tlast0;
    assign o_tdata  = sel ? tdata1 : tdata0;

    ascii_field_streamer #(.INPUT_WIDTH(W), .APPEND_CRLF(1'b1)) dut_crlf (
        .clk_i(clk), .reset_i(rst), .field_i(field), .start_i(start1), .idle_o(idle1),
        .tdata_o(tdata1), .tvalid_o(tvalid1), .tready_i(tready), .tlast_o(tlast1)
    );

    ascii_field_streamer #(.INPUT_WIDTH(W), .APPEND_CRLF(1'b0)) dut_plain (
        .clk_i(clk), .reset_i(rst), .field_i(field), .start_i(start0), .idle_o(idle0),
        .tdata_o(tdata0), .tvalid_o(tvalid0), .tready_i(tready), .tlast_o(tlast0)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  obs_q[$];
    int          stall_viol;
    int          first_cyc;
    bit          timed_out;

    function automatic logic [W*8-1:0] str_field(input string s);
        logic [W*8-1:0] f;
        f = '0;
        for (int k = 0; k < s.len(); k++) f[(s.len()-1-k)*8 +: 8] = s[k];
        return f;
    endfunction

    function automatic logic [W*8-1:0] rand_field();
        logic [W*8-1:0] f;
        for (int i = 0; i < W; i++)
            f[i*8 +: 8] = ($urandom_range(99) < 40) ? 8'h00 : 8'($urandom_range(1, 255));
        return f;
    endfunction

    // Expected beats {last, data}: non-NUL chars left to right, optional CR LF, last flag on the final beat.
    function automatic void build_exp(input logic [W*8-1:0] f, input bit crlf);
        logic [8:0] t;
        exp_q.delete();
        for (int i = W - 1; i >= 0; i--)
            if (f[i*8 +: 8] != 8'h00) exp_q.push_back({1'b0, f[i*8 +: 8]});
        if (crlf) begin
            exp_q.push_back({1'b0, 8'h0D});
            exp_q.push_back({1'b0, 8'h0A});
        end
        if (exp_q.size() > 0) begin
            t = exp_q.pop_back();
            t[8] = 1'b1;
            exp_q.push_back(t);
        end
    endfunction

    task automatic pulse_start(input logic [W*8-1:0] f);
        @(negedge clk);
        field = f;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Accept beats with a random TREADY until TLAST; records stall-hold violations and latency.
    task automatic collect(input int pct, input int max_cyc);
        int         cyc;
        bit         done, pend;
        logic [7:0] pd;
        logic       pl;
        obs_q.delete();
        stall_viol = 0; first_cyc = -1; timed_out = 0;
        cyc = 0; done = 0; pend = 0; pd = 8'h00; pl = 1'b0;
        while (!done && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (pend && (o_tvalid !== 1'b1 || o_tdata !== pd || o_tlast !== pl)) stall_viol++;
            if (o_tvalid === 1'b1 && first_cyc < 0) first_cyc = cyc;
            tready = ($urandom_range(99) < pct);
            if (o_tvalid === 1'b1 && tready) begin
                obs_q.push_back({o_tlast, o_tdata});
                pend = 0;
                if (o_tlast === 1'b1) done = 1;
            end else begin
                pend = (o_tvalid === 1'b1);
                pd = o_tdata;
                pl = o_tlast;
            end
        end
        if (!done) timed_out = 1;
        @(negedge clk);
        tready = 1'b0;
        $display("stream sel=%0d beats=%0d first_valid_cyc=%0d", sel, obs_q.size(), first_cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tready = 1'b0; field = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (idle1 !== 1'b1) begin n_fail++; $display("FAIL reset_idle_crlf got=%b want=1", idle1); end
        n_cmp++; if (tvalid1 !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid_crlf got=%b want=0", tvalid1); end
        n_cmp++; if (tlast1 !== 1'b0) begin n_fail++; $display("FAIL reset_tlast_crlf got=%b want=0", tlast1); end
        n_cmp++; if (tdata1 !== 8'h00) begin n_fail++; $display("FAIL reset_tdata_crlf got=%h want=00", tdata1); end
        n_cmp++; if (idle0 !== 1'b1) begin n_fail++; $display("FAIL reset_idle_plain got=%b want=1", idle0); end
        n_cmp++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid_plain got=%b want=0", tvalid0); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (idle1 !== 1'b1 || idle0 !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle got=%b%b want=11", idle1, idle0); end
        $display("reset checked");
    endtask

    task automatic test_field(input bit crlf);
        logic [W*8-1:0] f;
        sel = crlf;
        f = str_field("000_abcd");
        build_exp(f, crlf);
        pulse_start(f);
        collect(100, 200);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL field_timeout crlf=%0d got=no_tlast want=tlast", crlf); end
        n_cmp++; if (first_cyc + 1 !== 13) begin n_fail++; $display("FAIL field_latency crlf=%0d got=%0d want=13", crlf, first_cyc + 1); end
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL field_count crlf=%0d got=%0d want=%0d", crlf, obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL field_beat%0d crlf=%0d got=%h want=%h", i, crlf, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (o_idle !== 1'b1) begin n_fail++; $display("FAIL field_idle_after crlf=%0d got=%b want=1", crlf, o_idle); end
    endtask

    task automatic test_all_zero();
        int  cyc;
        bit  saw_valid, got_idle;
        sel = 1'b1;
        build_exp('0, 1'b1);
        pulse_start('0);
        collect(100, 100);
        n_cmp++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL zero_crlf_count got=%0d want=2", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL zero_crlf_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        sel = 1'b0;
        tready = 1'b1;
        pulse_start('0);
        saw_valid = 0; got_idle = 0; cyc = 0;
        while (!got_idle && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (o_tvalid === 1'b1) saw_valid = 1;
            if (o_idle === 1'b1) got_idle = 1;
        end
        tready = 1'b0;
        n_cmp++; if (!got_idle) begin n_fail++; $display("FAIL zero_plain_idle got=busy want=idle_within_20"); end
        n_cmp++; if (saw_valid) begin n_fail++; $display("FAIL zero_plain_beats got=tvalid want=none"); end
        $display("all-zero plain idle after %0d cycles", cyc);
    endtask

    task automatic test_random_ready();
        logic [W*8-1:0] f;
        sel = 1'b1;
        f = str_field("000_abcd");
        build_exp(f, 1'b1);
        pulse_start(f);
        collect(30, 2000);
        n_cmp++; if (timed_out || obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (stall_viol !== 0) begin n_fail++; $display("FAIL stall_hold got=%0d want=0", stall_viol); end
        for (int r = 0; r < 12; r++) begin
            sel = 1'($urandom_range(1));
            f = rand_field();
            build_exp(f, sel);
            if (exp_q.size() == 0) begin
                f[7:0] = 8'h41;
                build_exp(f, sel);
            end
            pulse_start(f);
            collect(int'($urandom_range(30, 100)), 3000);
            n_cmp++; if (timed_out || obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count got=%0d want=%0d", r, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_beat%0d got=%h want=%h", r, i, obs_q[i], exp_q[i]); end
            end
            n_cmp++; if (stall_viol !== 0) begin n_fail++; $display("FAIL rand%0d_hold got=%0d want=0", r, stall_viol); end
        end
    endtask

    task automatic test_start_ignored();
        logic [W*8-1:0] f1, f2;
        sel = 1'b1;
        f1 = str_field("Hello42");
        f2 = str_field("ZZZZZZZZZZZZ");
        build_exp(f1, 1'b1);
        pulse_start(f1);
        fork
            collect(60, 1000);
            begin
                repeat (16) @(negedge clk);
                field = f2;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        n_cmp++; if (timed_out || obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL midstart_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midstart_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [W*8-1:0] f2;
        bit found;
        sel = 1'b1;
        tready = 1'b0;
        pulse_start(str_field("AB"));
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (o_tvalid === 1'b1) found = 1;
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL rstmid_valid got=0 want=1"); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid got=%b want=0", o_tvalid); end
        n_cmp++; if (o_idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle got=%b want=1", o_idle); end
        rst = 1'b0;
        f2 = str_field("xy9");
        build_exp(f2, 1'b1);
        pulse_start(f2);
        collect(100, 200);
        n_cmp++; if (timed_out || obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rstmid_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        int busy;
        sel = 1'b1;
        pulse_start(str_field("Q"));
        tready = 1'b1;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (o_tvalid === 1'b1 && o_tlast === 1'b1) begin
                field = str_field("NEXT");
                start = 1'b1;
                seen = 1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL b2b_lf got=no_tlast want=tlast"); end
        n_cmp++; if (o_idle !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got=%b want=1", o_idle); end
        busy = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_tvalid !== 1'b0 || o_idle !== 1'b1) busy++;
        end
        tready = 1'b0;
        n_cmp++; if (busy !== 0) begin n_fail++; $display("FAIL b2b_ignored got=%0d want=0", busy); end
        $display("back-to-back start checked");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tready = 1'b0; sel = 1'b1; field = '0;
        test_reset();
        test_field(1'b1);
        test_field(1'b0);
        test_all_zero();
        test_random_ready();
        test_start_ignored();
        test_reset_midstream();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
